// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of a synchronous FIFO
//   among NUM_REQ requesters. Throttles on full/almostfull so that no granted
//   write is dropped, and flags any write the FIFO fails to acknowledge.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   arb_en            0 blocks new grants (writes already registered complete)
//   req, req_data     per-requester level request and data word (i*W +: W)
//   gnt               registered one-hot pulse: requester's word is written now
//   fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow   FIFO status
//   fifo_wr_en, fifo_data_in                                 FIFO write port
//   busy              state is not IDLE
//   err, err_clr      sticky error flag and its synchronous clear
//   gnt_cnt           per-requester saturating grant counters (16 bit each),
//                     present only when FIFO_ARB_STATS_EN is defined
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          busy,
    output logic                          err,
    input  logic                          err_clr
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         gnt_cnt
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_words;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rot;
    logic [PW-1:0]      rr_ptr, rr_next, pick, pick_off;
    logic [PW:0]        pick_sum;
    logic               any_elig, can_issue, issue;
    logic               ack_pipe;
    logic               err_set;

    assign req_words = req_data;

    // The requester holding a gnt pulse has not yet dropped/advanced its
    // request, so it must not be picked again this cycle.
    assign eligible = req & ~gnt;
    assign any_elig = |eligible;

    // A write in flight while almostfull is high will take the last slot;
    // reads are not visible here, so this is deliberately conservative.
    assign can_issue = arb_en & ~fifo_full & ~(fifo_almostfull & fifo_wr_en);
    assign issue     = any_elig & can_issue;
    assign busy      = (state != S_IDLE);

    // Round-robin pick: rotate the eligible set so rr_ptr lands on bit 0,
    // take the lowest set bit, then rotate the offset back (mod NUM_REQ).
    always_comb begin
        rot      = NUM_REQ'({eligible, eligible} >> rr_ptr);
        pick_off = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (rot[off]) pick_off = PW'(off);
        end
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= (PW+1)'(NUM_REQ))
            pick = PW'(pick_sum - (PW+1)'(NUM_REQ));
        else
            pick = pick_sum[PW-1:0];
        rr_next = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + PW'(1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM next state. The issue decision itself (issue) is independent of
    // the current state; the state only records idle/issuing/back-pressured.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (any_elig) state_next = can_issue ? S_ISSUE : S_HOLD;
            end
            S_ISSUE: begin
                if (!any_elig)      state_next = S_IDLE;
                else if (!can_issue) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (!any_elig)     state_next = S_IDLE;
                else if (can_issue) state_next = S_ISSUE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Write port, grant pulse and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en   <= 1'b0;
            gnt          <= '0;
            fifo_data_in <= '0;
            rr_ptr       <= '0;
        end else begin
            fifo_wr_en <= issue;
            gnt        <= issue ? (NUM_REQ'(1) << pick) : '0;
            if (issue) begin
                fifo_data_in <= req_words[pick];
                rr_ptr       <= rr_next;
            end
        end
    end

    // The FIFO acks a write one cycle after it sees wr_en, so compare the
    // ack against wr_en delayed by one. Any mismatch, or an overflow while
    // writing, is an error. Set wins over clear.
    assign err_set = (fifo_wr_ack != ack_pipe) | (fifo_overflow & fifo_wr_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_pipe <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack_pipe <= fifo_wr_en;
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (err_clr) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: drives 4 requesters against a depth-8 FIFO
// model and checks grants/data against a queue of expected grants.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic           clk;
    logic           rst_n;
    logic           arb_en;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           busy, err, err_clr;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] gnt_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .arb_en          (arb_en),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .busy            (busy),
        .err             (err),
        .err_clr         (err_clr)
`ifdef FIFO_ARB_STATS_EN
        ,
        .gnt_cnt         (gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model (depth 8, ack/overflow one cycle later) ----
    int   cnt;
    logic ack_r, ovf_r, rd_en, ack_kill;
    int   wr_total  = 0;
    int   ovf_total = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 0;
            ack_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            cnt   <= cnt + ((fifo_wr_en && cnt < DEPTH) ? 1 : 0)
                         - ((rd_en && cnt > 0) ? 1 : 0);
            ack_r <= fifo_wr_en && (cnt < DEPTH);
            ovf_r <= fifo_wr_en && (cnt >= DEPTH);
            if (fifo_wr_en && cnt < DEPTH)  wr_total  <= wr_total + 1;
            if (fifo_wr_en && cnt >= DEPTH) ovf_total <= ovf_total + 1;
        end
    end

    assign fifo_full       = (cnt >= DEPTH);
    assign fifo_almostfull = (cnt >= DEPTH - 1);
    assign fifo_wr_ack     = ack_r & ~ack_kill;
    assign fifo_overflow   = ovf_r;

    // ---------------- scoreboard ----------------
    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t         q[$];
    int           seq[N];
    int           exp_n[N];
    logic [N-1:0] one_shot;
    logic [W-1:0] last_data;
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [W-1:0] make_data(int i, int n);
        return {i[3:0], n[11:0]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(int i);
        exp_t e;
        e.idx  = i;
        e.data = make_data(i, exp_n[i]);
        exp_n[i]++;
        last_data = e.data;
        q.push_back(e);
    endtask

    // One clock; outputs are sampled on the falling edge, then the requester
    // side reacts to a grant (next word, or drop a one-shot request).
    task automatic step();
        exp_t         e;
        logic [N-1:0] oh;
        @(negedge clk);
        chk("wr_en_vs_gnt", 32'(fifo_wr_en), 32'(|gnt));
        if (gnt != '0) begin
            if (q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                e  = q.pop_front();
                oh = N'(1) << e.idx;
                chk("gnt_order", 32'(gnt), 32'(oh));
                chk("gnt_data", 32'(fifo_data_in), 32'(e.data));
            end
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    seq[i]++;
                    req_data[i*W +: W] = make_data(i, seq[i]);
                    if (one_shot[i]) req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(string tag, int bound, output int used);
        used = 0;
        while (q.size() > 0 && used < bound) begin
            step();
            used++;
        end
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        req      = '0;
        one_shot = '0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int used, wbase, obase;
        arb_en   = 1'b0;
        err_clr  = 1'b0;
        rd_en    = 1'b0;
        ack_kill = 1'b0;
        req      = '0;
        one_shot = '0;
        for (int i = 0; i < N; i++) begin
            seq[i]   = 0;
            exp_n[i] = 0;
            req_data[i*W +: W] = make_data(i, 0);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_data", 32'(fifo_data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Idle: no requests for 10 cycles
        rst_n  = 1'b1;
        arb_en = 1'b1;
        rd_en  = 1'b1;
        repeat (10) step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(err), 32'd0);

        // Fairness: all four held, FIFO drained -> 0,1,2,3,0,1,2,3 back to back
        for (int k = 0; k < 8; k++) push(k % N);
        req = 4'hF;
        drain("fair_drain", 20, used);
        chk("fair_cycles", 32'(used), 32'd8);
        req = '0;
        repeat (3) step();
        chk("fair_data_hold", 32'(fifo_data_in), 32'(last_data));
        chk("fair_busy_end", 32'(busy), 32'd0);

        // Fill: no reads, req[2]+req[3] held -> exactly 8 writes, then HOLD
        do_reset();
        rd_en = 1'b0;
        wbase = wr_total;
        obase = ovf_total;
        for (int k = 0; k < 8; k++) push((k % 2 == 0) ? 2 : 3);
        req = 4'b1100;
        drain("fill_drain", 30, used);
        repeat (6) step();
        chk("fill_writes", 32'(wr_total - wbase), 32'd8);
        chk("fill_overflow", 32'(ovf_total - obase), 32'd0);
        chk("fill_full", 32'(fifo_full), 32'd1);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_err", 32'(err), 32'd0);

        // Resume: one read -> exactly one grant, next in order (requester 2)
        push(2);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        drain("resume_drain", 10, used);
        repeat (6) step();
        chk("resume_writes", 32'(wr_total - wbase), 32'd9);
        chk("resume_overflow", 32'(ovf_total - obase), 32'd0);
        chk("resume_err", 32'(err), 32'd0);

        // arb_en low: request waits in HOLD, granted once enabled
        do_reset();
        rd_en    = 1'b1;
        arb_en   = 1'b0;
        one_shot = 4'b0010;
        req      = 4'b0010;
        repeat (4) step();
        chk("arb_dis_busy", 32'(busy), 32'd1);
        push(1);
        arb_en = 1'b1;
        drain("arb_en_drain", 5, used);
        repeat (3) step();
        chk("arb_en_busy_end", 32'(busy), 32'd0);

        // Error: missing ack -> err two cycles after wr_en, sticky until clear
        do_reset();
        rd_en    = 1'b1;
        ack_kill = 1'b1;
        one_shot = 4'b0001;
        push(0);
        req = 4'b0001;
        drain("err_drain", 5, used);
        step();
        chk("err_not_yet", 32'(err), 32'd0);
        step();
        chk("err_set", 32'(err), 32'd1);
        ack_kill = 1'b0;
        repeat (3) step();
        chk("err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // Single requester held: granted every other cycle
        do_reset();
        rd_en = 1'b1;
        for (int k = 0; k < 5; k++) push(1);
        req = 4'b0010;
        drain("single_drain", 20, used);
        chk("single_cycles", 32'(used), 32'd9);
        req = '0;
        step();
`ifdef FIFO_ARB_STATS_EN
        chk("stats_cnt1", 32'(gnt_cnt[16 +: 16]), 32'd5);
        chk("stats_cnt0", 32'(gnt_cnt[0 +: 16]), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("stats_clr", 32'(gnt_cnt[16 +: 16]), 32'd0);
`endif
        chk("final_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
